alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Adds XOR, signed/unsigned compare and shifts as 1-cycle ops, plus iterative unsigned multiply and divide/remainder.
- Registers result and Zero flag.
- Sits in the execute stage of the multi-cycle RISC-V core; the controller issues one operation and waits for done.

Parameters:
- WIDTH, 32, datapath width in bits; power of two, 8 to 64. Shift amount is the low log2(WIDTH) bits of src_B.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- start  input  1  request; sampled only when busy=0.
- ALU_Control  input  4  operation select, sampled with start.
- src_A  input  WIDTH  operand A, sampled with start.
- src_B  input  WIDTH  operand B, sampled with start.
- out  output  WIDTH  registered result; held until next accepted start.
- Zero  output  1  registered; 1 when out==0, updated with out.
- busy  output  1  iterative op in progress; start ignored.
- done  output  1  one-cycle pulse; out/Zero are valid and new.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a rising edge): out=0, Zero=1, busy=0, done=0, state=IDLE, counter=0. Reset mid-operation aborts; no done is produced.
- Opcodes, 1-cycle:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor.
  - 0101 slt (signed), 0110 sltu (unsigned): result is zero-extended 0/1.
  - 0111 sll, 1000 srl, 1001 sra (arithmetic, sign fill).
- Opcodes, iterative:
  - 1010 mul (low WIDTH bits of A*B), 1011 mulhu (high WIDTH bits, unsigned).
  - 1100 divu (quotient), 1101 remu (remainder).
- Opcodes 1110 and 1111: treated as 1-cycle ops, result 0, Zero=1.
- Add/sub wrap modulo 2^WIDTH; no overflow flag.
- States: IDLE, RUN, DONE.
  - IDLE/DONE with start=1 and a 1-cycle op: result registered at that edge; go to DONE (done=1 for the next cycle).
  - IDLE/DONE with start=1 and an iterative op: latch operands; counter=WIDTH; go to RUN, busy=1.
  - IDLE/DONE with start=0: go to IDLE, done=0.
  - RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle; counter decrements.
  - RUN, last step (counter==1): result written to out/Zero; go to DONE, busy=0.
- Latency, start accepted at edge k:
  - 1-cycle ops: done=1 during cycle after edge k.
  - Iterative ops: busy=1 after edges k through k+WIDTH-1; done=1 after edge k+WIDTH.
- Start while busy=1: ignored. Operands/opcode are not re-sampled, and the in-flight op completes unaffected.
- Back-to-back: start in the DONE cycle is accepted (busy=0 there). done may then stay high on consecutive cycles for consecutive 1-cycle ops.
- Divide by zero: divu result = all ones; remu result = src_A. Still takes WIDTH cycles.
- Operand changes after acceptance have no effect. out is unchanged during RUN, and Zero tracks out only.
- Multiply uses a 2*WIDTH product accumulator; mul and mulhu share the datapath. Divide uses a WIDTH+1-bit partial remainder.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with start=1 → out=0, Zero=1, busy=0, done=0. Release; with start=0, state stays quiet.
- 1-cycle ops (WIDTH=32):
  - add 0xFFFFFFFF+1 → out=0, Zero=1, done pulse 1 cycle after start.
  - slt A=0xFFFFFFFF, B=1 → 1; sltu same operands → 0.
  - sra 0x80000000 by 4 → 0xF8000000.
  - sll with B=0x25 → shift by 5.
- mul A=0x12345678, B=0x9ABCDEF0:
  - mul → out=0x242D2080, done exactly 32 edges after accepted start, busy high for 32 cycles.
  - mulhu → 0x0B00EA4E.
- divu A=100, B=7 → out=14; remu → 2; divu A=5, B=0 → 0xFFFFFFFF; remu A=5, B=0 → 5; all with 32-cycle latency.
- Start pulsed with different opcode/operands mid-RUN of divu 100/7 → ignored; result still 14 with unchanged timing. rst_n=0 mid-RUN → no done, busy=0 next cycle.
- Back-to-back: start held high with add, xor, mul issued on consecutive accepted cycles → done on cycles 1 and 2, then mul result 32 edges after its acceptance. Zero correct for each.

Source files
------------

// File: rtl/alu_muldiv.sv
// Execute-stage ALU with registered result/Zero; 1-cycle ops finish in one edge, mul/div iterate WIDTH edges.
// busy is high while iterating; start is ignored then, and the in-flight op completes untouched.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALU_Control,
    input  logic [WIDTH-1:0] src_A,
    input  logic [WIDTH-1:0] src_B,
    output logic [WIDTH-1:0] out,
    output logic             Zero,
    output logic             busy,
    output logic             done
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             hi_q, hi_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zero_q, zero_d;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] fast_res;
    logic             is_iter;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH:0]   acc_step;
    logic [WIDTH-1:0] lo_step;
    logic [WIDTH-1:0] iter_res;

    assign shamt   = src_B[SHW-1:0];
    assign is_iter = (ALU_Control >= 4'd10) && (ALU_Control <= 4'd13);

    always_comb begin
        fast_res = '0;
        case (ALU_Control)
            4'b0000: fast_res = src_A + src_B;
            4'b0001: fast_res = src_A - src_B;
            4'b0010: fast_res = src_A & src_B;
            4'b0011: fast_res = src_A | src_B;
            4'b0100: fast_res = src_A ^ src_B;
            4'b0101: fast_res = {{(WIDTH-1){1'b0}}, ($signed(src_A) < $signed(src_B))};
            4'b0110: fast_res = {{(WIDTH-1){1'b0}}, (src_A < src_B)};
            4'b0111: fast_res = src_A << shamt;
            4'b1000: fast_res = src_A >> shamt;
            4'b1001: fast_res = $signed(src_A) >>> shamt;
            default: fast_res = '0;
        endcase
    end

    // Shared iteration registers: acc is the product high half or the partial
    // remainder; lo is the multiplier being shifted out or the dividend/quotient.
    always_comb begin
        mul_sum  = {1'b0, acc_q[WIDTH-1:0]} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_sh   = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd_q};
        if (div_q) begin
            if (!div_diff[WIDTH]) begin
                acc_step = div_diff;
                lo_step  = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = div_sh;
                lo_step  = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = {1'b0, mul_sum[WIDTH:1]};
            lo_step  = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        iter_res = hi_q ? acc_step[WIDTH-1:0] : lo_step;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        hi_d    = hi_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        out_d   = out_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (is_iter) begin
                        div_d   = ALU_Control[2];
                        hi_d    = ALU_Control[0];
                        opnd_d  = ALU_Control[2] ? src_B : src_A;
                        lo_d    = ALU_Control[2] ? src_A : src_B;
                        acc_d   = '0;
                        cnt_d   = CW'(WIDTH);
                        state_d = RUN;
                    end else begin
                        out_d   = fast_res;
                        zero_d  = (fast_res == '0);
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = acc_step;
                lo_d  = lo_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    out_d   = iter_res;
                    zero_d  = (iter_res == '0);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            hi_q    <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            out_q   <= '0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
        end
    end

    assign out  = out_q;
    assign Zero = zero_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed vector bench for alu_muldiv at WIDTH=32: table of ops plus abort/ignore/back-to-back sequences.
module tb_alu_muldiv;
    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [3:0]    ALU_Control;
    logic [W-1:0]  src_A;
    logic [W-1:0]  src_B;
    logic [W-1:0]  out;
    logic          Zero;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ALU_Control (ALU_Control),
        .src_A       (src_A),
        .src_B       (src_B),
        .out         (out),
        .Zero        (Zero),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input int idx, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    // Drive a request at the falling edge; return just after the accepting edge with start dropped.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; ALU_Control = op; src_A = a; src_B = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input logic [W-1:0] prev, output int edges, output int busy_n,
                             output logic moved);
        edges = 0; busy_n = 0; moved = 1'b0;
        while (!done && edges < 200) begin
            if (busy) busy_n++;
            if (out !== prev) moved = 1'b1;
            @(posedge clk); #1;
            edges++;
        end
    endtask

    initial begin
        int          edges;
        int          busy_n;
        int          done_n;
        logic        moved;
        logic        iter;
        logic [W-1:0] prev;

        // Reset held with start asserted
        rst_n = 1'b0; start = 1'b1; ALU_Control = 4'b0000; src_A = 32'd5; src_B = 32'd3;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out",  0, out,  0);
        check("rst_zero", 0, Zero, 1);
        check("rst_busy", 0, busy, 0);
        check("rst_done", 0, done, 0);
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_done", 0, done, 0);
        check("idle_busy", 0, busy, 0);
        check("idle_out",  0, out,  0);

        add_vec(4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
        add_vec(4'b0001, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE);
        add_vec(4'b0010, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
        add_vec(4'b0011, 32'h0000_0F00, 32'h0000_00F0, 32'h0000_0FF0);
        add_vec(4'b0100, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_0000);
        add_vec(4'b0101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
        add_vec(4'b0110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
        add_vec(4'b0110, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001);
        add_vec(4'b0111, 32'h0000_0003, 32'h0000_0025, 32'h0000_0060);
        add_vec(4'b1000, 32'h8000_0000, 32'h0000_003F, 32'h0000_0001);
        add_vec(4'b1001, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000);
        add_vec(4'b1001, 32'h4000_0000, 32'h0000_0004, 32'h0400_0000);
        add_vec(4'b1110, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000);
        add_vec(4'b1111, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000);
        add_vec(4'b1010, 32'h1234_5678, 32'h9ABC_DEF0, 32'h242D_2080);
        add_vec(4'b1011, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E);
        add_vec(4'b1010, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000);
        add_vec(4'b1100, 32'd100,        32'd7,        32'd14);
        add_vec(4'b1101, 32'd100,        32'd7,        32'd2);
        add_vec(4'b1100, 32'd5,          32'd0,        32'hFFFF_FFFF);
        add_vec(4'b1101, 32'd5,          32'd0,        32'd5);
        add_vec(4'b1100, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF);
        add_vec(4'b1101, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F);

        for (int i = 0; i < vecs.size(); i++) begin
            iter = (vecs[i].op >= 4'd10) && (vecs[i].op <= 4'd13);
            prev = out;
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(prev, edges, busy_n, moved);
            check("done_seen", i, done, 1);
            check("latency",   i, edges,  iter ? W : 0);
            check("busy_cyc",  i, busy_n, iter ? W : 0);
            check("result",    i, out,  vecs[i].exp);
            check("zero",      i, Zero, (vecs[i].exp == '0) ? 1 : 0);
            if (iter) check("out_held", i, moved, 0);
            @(posedge clk); #1;
            check("done_pulse", i, done, 0);
        end

        // Start pulse with new opcode/operands during divu 100/7
        issue(4'b1100, 32'd100, 32'd7);
        edges = 0;
        while (!done && edges < 200) begin
            if (edges == 5) begin
                start = 1'b1; ALU_Control = 4'b0000; src_A = 32'd1; src_B = 32'd1;
            end else if (edges == 6) begin
                start = 1'b0; src_A = 32'd999; src_B = 32'd3;
            end
            @(posedge clk); #1;
            edges++;
        end
        check("ign_latency", 0, edges, W);
        check("ign_result",  0, out, 14);
        check("ign_zero",    0, Zero, 0);

        // Reset during a multiply aborts without a done
        @(posedge clk); #1;
        issue(4'b1010, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) @(posedge clk);
        #1;
        check("mid_busy_pre", 0, busy, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", 0, busy, 0);
        check("abort_done", 0, done, 0);
        check("abort_out",  0, out,  0);
        check("abort_zero", 0, Zero, 1);
        rst_n = 1'b1;
        done_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) done_n++;
        end
        check("abort_no_done", 0, done_n, 0);

        // Back-to-back: add, xor, mul with start held high
        @(negedge clk);
        start = 1'b1; ALU_Control = 4'b0000; src_A = 32'hFFFF_FFFF; src_B = 32'h1;
        @(posedge clk); #1;
        check("b2b_add_done", 0, done, 1);
        check("b2b_add_out",  0, out,  0);
        check("b2b_add_zero", 0, Zero, 1);
        ALU_Control = 4'b0100; src_A = 32'h0000_000F; src_B = 32'h0000_00F0;
        @(posedge clk); #1;
        check("b2b_xor_done", 0, done, 1);
        check("b2b_xor_out",  0, out,  32'h0000_00FF);
        check("b2b_xor_zero", 0, Zero, 0);
        ALU_Control = 4'b1010; src_A = 32'd3; src_B = 32'd5;
        @(posedge clk); #1;
        check("b2b_mul_busy", 0, busy, 1);
        check("b2b_mul_done", 0, done, 0);
        ALU_Control = 4'b0001; src_A = 32'd77; src_B = 32'd11;
        edges = 0;
        while (!done && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;
        check("b2b_mul_lat",  0, edges, W);
        check("b2b_mul_out",  0, out,   32'd15);
        check("b2b_mul_zero", 0, Zero,  0);
        @(posedge clk); #1;
        check("b2b_end_done", 0, done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
